// File: rtl/vga_pkg.sv
// Shared timing constants for the 800x600 @ 60 Hz (40 MHz pixel clock) mode.
// BLANK/SYNC_TIME values are inclusive end offsets from their START value.
package vga_pkg;

  localparam logic [10:0] HOR_TOTAL_TIME  = 11'd1056;
  localparam logic [10:0] HOR_BLANK_START = 11'd800;
  localparam logic [10:0] HOR_BLANK_TIME  = 11'd255;
  localparam logic [10:0] HOR_SYNC_START  = 11'd840;
  localparam logic [10:0] HOR_SYNC_TIME   = 11'd127;

  localparam logic [10:0] VER_TOTAL_TIME  = 11'd628;
  localparam logic [10:0] VER_BLANK_START = 11'd600;
  localparam logic [10:0] VER_BLANK_TIME  = 11'd27;
  localparam logic [10:0] VER_SYNC_START  = 11'd601;
  localparam logic [10:0] VER_SYNC_TIME   = 11'd3;

  // True when value lies in [start, start+len] inclusive.
  function automatic logic in_window(input logic [10:0] value,
                                     input logic [10:0] start,
                                     input logic [10:0] len);
    return (value >= start) && (value <= (start + len));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with sync and blanking
// flags. Flags are derived from the next counter values so that every
// registered output describes the same pixel position.
module vga_timing
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk
);

  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;
  logic        hsync_nxt;
  logic        hblnk_nxt;
  logic        vsync_nxt;
  logic        vblnk_nxt;

  // Next raster position and the flags belonging to that position.
  always_comb begin
    hcount_nxt = '0;
    vcount_nxt = vcount;
    if (hcount != (HOR_TOTAL_TIME - 11'd1)) begin
      hcount_nxt = hcount + 11'd1;
    end else begin
      if (vcount != (VER_TOTAL_TIME - 11'd1)) begin
        vcount_nxt = vcount + 11'd1;
      end else begin
        vcount_nxt = '0;
      end
    end
    hblnk_nxt = in_window(hcount_nxt, HOR_BLANK_START, HOR_BLANK_TIME);
    hsync_nxt = in_window(hcount_nxt, HOR_SYNC_START,  HOR_SYNC_TIME);
    vblnk_nxt = in_window(vcount_nxt, VER_BLANK_START, VER_BLANK_TIME);
    vsync_nxt = in_window(vcount_nxt, VER_SYNC_START,  VER_SYNC_TIME);
  end

  // Output registers; reset wins over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
      hsync  <= 1'b0;
      hblnk  <= 1'b0;
      vsync  <= 1'b0;
      vblnk  <= 1'b0;
    end else begin
      hcount <= hcount_nxt;
      vcount <= vcount_nxt;
      hsync  <= hsync_nxt;
      hblnk  <= hblnk_nxt;
      vsync  <= vsync_nxt;
      vblnk  <= vblnk_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a position-in-frame reference model
// (cycles since reset release) predicts counters and flags every clock.
`timescale 1ns/1ps
module tb_vga_timing;

  localparam int unsigned HTOT  = 1056;
  localparam int unsigned VTOT  = 628;
  localparam int unsigned FRAME = HTOT * VTOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned t           = 0;
  int unsigned cycle       = 0;

  vga_timing dut (
    .clk    (clk),
    .rst    (rst),
    .vcount (vcount),
    .vsync  (vsync),
    .vblnk  (vblnk),
    .hcount (hcount),
    .hsync  (hsync),
    .hblnk  (hblnk)
  );

  always #12.5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (miscompares <= 25)
        $display("FAIL %s: got %0d expected %0d (t=%0d cycle=%0d)", tag, got, exp, t, cycle);
    end
  endtask

  // One clock: advance the model with the rst seen at this edge, then compare.
  task automatic step();
    int unsigned eh, ev;
    @(posedge clk);
    #1;
    cycle++;
    if (rst) t = 0;
    else     t = (t + 1) % FRAME;
    eh = t % HTOT;
    ev = t / HTOT;
    check("hcount", 32'(hcount), eh);
    check("vcount", 32'(vcount), ev);
    check("hblnk",  32'(hblnk),  32'(eh >= 800 && eh <= 1055));
    check("hsync",  32'(hsync),  32'(eh >= 840 && eh <= 967));
    check("vblnk",  32'(vblnk),  32'(ev >= 600 && ev <= 627));
    check("vsync",  32'(vsync),  32'(ev >= 601 && ev <= 604));
    check("hrange", 32'(hcount < 11'd1056), 32'd1);
    check("vrange", 32'(vcount < 11'd628),  32'd1);
  endtask

  initial begin
    int unsigned n;
    int unsigned fall1, fall2, nfall;
    logic        vsync_prev;
    logic        found;

    // Initial reset held for two clocks.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Random run lengths interleaved with random-length reset pulses.
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(4000, 20);
      for (int k = 0; k < int'(n); k++) step();
      rst = 1'b1;
      n = $urandom_range(3, 1);
      for (int k = 0; k < int'(n); k++) step();
      rst = 1'b0;
    end

    // Run into the vsync region and reset at (900, 602).
    found = 1'b0;
    for (int k = 0; k < 700000; k++) begin
      if (hcount == 11'd900 && vcount == 11'd602) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("reach_900_602", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("resume_h1", 32'(hcount), 32'd1);

    // Two full frames: measure the distance between vsync falling edges.
    nfall = 0;
    fall1 = 0;
    fall2 = 0;
    vsync_prev = vsync;
    for (int k = 0; k < 1400000; k++) begin
      step();
      if (vsync_prev && !vsync) begin
        check("vsync_fall_h0", 32'(hcount), 32'd0);
        if (nfall == 0) fall1 = cycle;
        else            fall2 = cycle;
        nfall++;
      end
      vsync_prev = vsync;
      if (nfall == 2) break;
    end
    check("vsync_falls_seen", nfall, 32'd2);
    check("frame_period", (nfall == 2) ? (fall2 - fall1) : 32'd0, FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 No module parameters; all timing constants come from the shared package vga_pkg.
REQ-002 clk  input  1  system clock, 40 MHz pixel clock (800x600 @ 60 Hz); all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 vcount  output  11  current line number, 0..VER_TOTAL_TIME-1.
REQ-005 vsync  output  1  vertical sync, active-high.
REQ-006 vblnk  output  1  vertical blanking flag, active-high.
REQ-007 hcount  output  11  current pixel within line, 0..HOR_TOTAL_TIME-1.
REQ-008 hsync  output  1  horizontal sync, active-high.
REQ-009 hblnk  output  1  horizontal blanking flag, active-high.

Function
REQ-010 All outputs SHALL be registered; hcount, vcount and all four flags SHALL update on the same clk edge and always describe the same pixel position.
REQ-011 hcount SHALL increment by 1 per clock and wrap from HOR_TOTAL_TIME-1 (1055) to 0.
REQ-012 vcount SHALL increment by 1 only on the cycle hcount wraps to 0, and SHALL wrap from VER_TOTAL_TIME-1 (627) to 0 when hcount wraps at 1055; otherwise vcount holds.
REQ-013 hblnk SHALL be 1 iff HOR_BLANK_START <= hcount <= HOR_BLANK_START+HOR_BLANK_TIME (800..1055), else 0.
REQ-014 hsync SHALL be 1 iff HOR_SYNC_START <= hcount <= HOR_SYNC_START+HOR_SYNC_TIME (840..967, 128 clocks), else 0.
REQ-015 vblnk SHALL be 1 iff VER_BLANK_START <= vcount <= VER_BLANK_START+VER_BLANK_TIME (600..627), else 0.
REQ-016 vsync SHALL be 1 iff VER_SYNC_START <= vcount <= VER_SYNC_START+VER_SYNC_TIME (601..604, 4 lines), else 0.
REQ-017 vsync/vblnk SHALL change only together with a vcount change (i.e. at hcount=0), never mid-line.
REQ-018 Flags SHALL be computed from the next-state counter values and registered, so no one-cycle lag relative to hcount/vcount.
REQ-019 hcount/vcount SHALL never leave their ranges; out-of-range is impossible by construction.
REQ-020 Frame period SHALL be 1056 x 628 = 663168 clocks.

Reset
REQ-021 While rst=1 at a rising clk edge: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0 on the following edge output.
REQ-022 Reset asserted mid-frame SHALL restart from (0,0) with all flags 0; counting resumes on the first edge with rst=0 (next hcount=1).
REQ-023 Reset SHALL take priority over counting in the same cycle.

Structure
REQ-024 vga_pkg SHALL hold: HOR_TOTAL_TIME=1056, HOR_BLANK_START=800, HOR_BLANK_TIME=255, HOR_SYNC_START=840, HOR_SYNC_TIME=127, VER_TOTAL_TIME=628, VER_BLANK_START=600, VER_BLANK_TIME=27, VER_SYNC_START=601, VER_SYNC_TIME=3 (BLANK/SYNC_TIME = inclusive end offset).
REQ-025 Single module: one sequential block for registers, one combinational block for next-state counters and flags; no sub-module.

Verification
REQ-026 Reset: hold rst=1 for 2 clocks -> all outputs 0; after release hcount steps 0,1,2...
REQ-027 Horizontal edges: hcount 799->hblnk 0, 800->1, 1055->1, 0->0; hcount 839->hsync 0, 840->1, 967->1, 968->0.
REQ-028 Line/frame wrap: at (hcount=1055, vcount=5) next is (0,6); at (1055,627) next is (0,0) with vblnk=0, vsync=0.
REQ-029 Vertical flags: vblnk 1 for vcount 600..627; vsync 1 for vcount 601..604; two successive vsync falling edges 663168 clocks apart.
REQ-030 Range assertions every clock: hcount<1056, vcount<628, and flag/counter relations of REQ-013..016 hold from reset release to two vsync falling edges.
REQ-031 Mid-frame reset at (hcount=900, vcount=602) -> next outputs (0,0), all flags 0, normal sequence resumes.
